counter_sequencer: RTL and testbench
====================================

# counter_sequencer

Run-control sequencer for the LED counter datapath. It replaces the derived-clock divider with a single-clock prescaler that issues step enables, and it counts a CNT_W-bit value up or down between 0 and a programmable limit. Start, stop, load and one-shot or auto-reload modes are controlled from board switches or buttons. It sits between the debounced user inputs and the LED outputs, entirely in the Clk domain.

## Interface
Parameters:
- CNT_W, 4: count width.
- DIV_W, 27: prescaler width.

Ports:
- Clk  in  1  system clock (100 MHz on board).
- Reset  in  1  synchronous, active-high; sampled on posedge Clk.
- Start  in  1  level; sampled each cycle.
- Stop  in  1  level; sampled each cycle.
- Load  in  1  load Count from Load_val.
- Load_val  in  CNT_W  load value.
- Limit  in  CNT_W  terminal value (up) / reload value (down).
- Dir  in  1  1 = up, 0 = down.
- Reload  in  1  1 = auto-reload at terminal, 0 = one-shot.
- Div  in  DIV_W  step period minus 1, in Clk cycles.
- Count  out  CNT_W  registered counter value.
- Tick  out  1  registered one-cycle pulse, high in the cycle after each step edge.
- Tc  out  1  registered one-cycle pulse, high in the cycle after a terminal step.
- Busy  out  1  high in RUN.
- Done  out  1  high in DONE.

## Operation
- States: IDLE, RUN, PAUSE, DONE (binary-encoded, registered).
- Reset:
  - state = IDLE; Count = 0; prescaler = 0; Tick = Tc = Busy = Done = 0.
  - Reset overrides every other input.
- Input priority per cycle: Reset > Load > Stop > Start > step.
- Load (any state, not Reset):
  - Count <= Load_val; prescaler <= 0; no step that cycle.
  - DONE -> IDLE; all other states unchanged.
- IDLE:
  - Start & !Stop -> RUN, prescaler <= 0.
  - Count holds.
- RUN:
  - Stop -> PAUSE; prescaler and Count hold.
  - Otherwise prescaler increments. When prescaler == Div, prescaler <= 0 and a step occurs at that edge.
- Step, with terminal = Limit if Dir = 1, else 0:
  - Count != terminal: Count <= Count + 1 (Dir = 1) or Count - 1 (Dir = 0), modulo 2^CNT_W.
  - Count == terminal, Reload = 1: Count <= 0 (Dir = 1) or Limit (Dir = 0); stay in RUN; Tc pulses.
  - Count == terminal, Reload = 0: Count holds; RUN -> DONE; Tc pulses.
- Up count starting above Limit: wraps through 2^CNT_W-1 -> 0, then terminates at Limit.
- PAUSE:
  - Start & !Stop -> RUN, resuming the held prescaler value (no restart of the period).
  - Stop alone: no effect.
- DONE:
  - Count holds.
  - Start & !Stop -> RUN with Count <= 0 (Dir = 1) or Limit (Dir = 0), prescaler <= 0.
- Limit, Dir, Reload and Div are sampled live each cycle, with no shadow registers.
- Div changed mid-period below the current prescaler value: the prescaler counts up through 2^DIV_W-1, wraps, and then matches.

## Timing
- All outputs are registered; there are no combinational input-to-output paths.
- Start sampled high at edge k (in IDLE): Busy = 1 after edge k. First step at edge k+Div+1; new Count and Tick visible from that edge.
- Step period in RUN = Div+1 cycles. Div = 0 steps every cycle.
- Tc coincides with Tick on the terminal step. Done rises at the same edge as that Tc (one-shot).
- Stop at edge k: no step at edge k, even if the prescaler equals Div.
- Load coincident with a step: Load wins; Count = Load_val and Tick = 0.
- Reset mid-RUN: the next cycle is IDLE with Count = 0; an in-flight Tick/Tc pulse is cleared.

## Test plan
- Reset, Div = 2, Dir = 1, Limit = 5, Reload = 1, Start 1 cycle:
  - Count steps 0 -> 1 -> … -> 5 -> 0 every 3 cycles.
  - Tc pulses once per wrap, aligned with Count = 0.
  - Busy stays 1.
- Dir = 0, Reload = 0, Limit = 3, Load_val = 3, Load then Start, Div = 0:
  - Count 3, 2, 1, 0 on consecutive cycles.
  - Tc and Done rise together; Count holds 0; Busy = 0.
- Div = 4, Stop asserted 2 cycles after a step, Start 10 cycles later:
  - No steps while paused.
  - Next step occurs 3 cycles after resume (prescaler preserved).
- Load_val = 9 asserted in the same cycle as a step in RUN:
  - Count = 9; Tick = 0; state stays RUN.
  - Load in DONE: state -> IDLE.
- Start and Stop high together in IDLE and in PAUSE: state unchanged.
- Reset asserted mid-RUN with Count = 7, coincident with a step:
  - Next cycle: Count = 0, IDLE, Tick = Tc = Busy = Done = 0.

Source files
------------

// File: rtl/counter_sequencer.sv
// counter_sequencer
//   Run-control sequencer for the LED counter. A single-clock prescaler
//   produces one step every Div+1 cycles while running. Each step moves
//   Count one value toward a terminal value (Limit when counting up, 0 when
//   counting down). At the terminal value the counter either reloads or stops.
//
//   Ports
//     Clk       system clock
//     Reset     synchronous, active-high
//     Start     level, enters or resumes RUN (ignored while Stop is high)
//     Stop      level, RUN -> PAUSE
//     Load      Count <= Load_val, prescaler cleared, DONE -> IDLE
//     Load_val  value for Load
//     Limit     terminal value (up) / reload value (down)
//     Dir       1 = up, 0 = down
//     Reload    1 = auto-reload at terminal, 0 = one-shot
//     Div       step period minus 1, in Clk cycles
//     Count     registered counter value
//     Tick      one-cycle pulse after each step
//     Tc        one-cycle pulse after a terminal step
//     Busy      high in RUN
//     Done      high in DONE
//
//   state | meaning
//   IDLE  | stopped, Count holds, waiting for Start
//   RUN   | prescaler advancing, a step is taken each time it reaches Div
//   PAUSE | stopped by Stop, prescaler and Count held for resume
//   DONE  | one-shot count reached terminal, Count holds

module counter_sequencer #(
  parameter int CNT_W = 4,
  parameter int DIV_W = 27
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             Start,
  input  logic             Stop,
  input  logic             Load,
  input  logic [CNT_W-1:0] Load_val,
  input  logic [CNT_W-1:0] Limit,
  input  logic             Dir,
  input  logic             Reload,
  input  logic [DIV_W-1:0] Div,
  output logic [CNT_W-1:0] Count,
  output logic             Tick,
  output logic             Tc,
  output logic             Busy,
  output logic             Done
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_PAUSE = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [DIV_W-1:0] pre_q, pre_d;
  logic             tick_q, tick_d;
  logic             tc_q, tc_d;
  logic             busy_q, done_q;

  logic [CNT_W-1:0] terminal;
  logic [CNT_W-1:0] reload_val;
  logic             go;

  assign terminal   = Dir ? Limit : '0;
  assign reload_val = Dir ? '0 : Limit;
  assign go         = Start & ~Stop;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    pre_d   = pre_q;
    tick_d  = 1'b0;
    tc_d    = 1'b0;

    if (Load) begin
      // Load beats any step due this cycle.
      cnt_d = Load_val;
      pre_d = '0;
      if (state_q == S_DONE) state_d = S_IDLE;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (go) begin
            state_d = S_RUN;
            pre_d   = '0;
          end
        end
        S_RUN: begin
          if (Stop) begin
            state_d = S_PAUSE;
          end else if (pre_q == Div) begin
            pre_d  = '0;
            tick_d = 1'b1;
            if (cnt_q != terminal) begin
              cnt_d = Dir ? cnt_q + CNT_W'(1) : cnt_q - CNT_W'(1);
            end else begin
              tc_d = 1'b1;
              if (Reload) cnt_d   = reload_val;
              else        state_d = S_DONE;
            end
          end else begin
            // Plain increment: if Div drops below pre_q mid-period the
            // prescaler runs through its full range before matching again.
            pre_d = pre_q + DIV_W'(1);
          end
        end
        S_PAUSE: begin
          // Prescaler is deliberately not cleared so the period resumes.
          if (go) state_d = S_RUN;
        end
        S_DONE: begin
          if (go) begin
            state_d = S_RUN;
            cnt_d   = reload_val;
            pre_d   = '0;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      pre_q   <= '0;
      tick_q  <= 1'b0;
      tc_q    <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      pre_q   <= pre_d;
      tick_q  <= tick_d;
      tc_q    <= tc_d;
      busy_q  <= (state_d == S_RUN);
      done_q  <= (state_d == S_DONE);
    end
  end

  assign Count = cnt_q;
  assign Tick  = tick_q;
  assign Tc    = tc_q;
  assign Busy  = busy_q;
  assign Done  = done_q;

endmodule

// File: tb/tb_counter_sequencer.sv
module tb_counter_sequencer;

  localparam int CW = 4;
  localparam int DW = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst, start, stop, load, dir, reload;
  logic [CW-1:0] load_val, limit;
  logic [DW-1:0] div;
  logic [CW-1:0] count;
  logic          tick, tc, busy, done;

  counter_sequencer #(.CNT_W(CW), .DIV_W(DW)) dut (
    .Clk(clk), .Reset(rst), .Start(start), .Stop(stop), .Load(load),
    .Load_val(load_val), .Limit(limit), .Dir(dir), .Reload(reload),
    .Div(div), .Count(count), .Tick(tick), .Tc(tc), .Busy(busy), .Done(done)
  );

  int n_total = 0;
  int n_pass  = 0;

  // Reference model: plain integers, advanced once per clock edge.
  localparam int M_IDLE = 0, M_RUN = 1, M_PAUSE = 2, M_DONE = 3;
  int m_st = M_IDLE, m_cnt = 0, m_pre = 0, m_tick = 0, m_tc = 0;

  task automatic model_edge();
    int term;
    int mod_c;
    int mod_p;
    mod_c  = 1 << CW;
    mod_p  = 1 << DW;
    m_tick = 0;
    m_tc   = 0;
    if (rst) begin
      m_st = M_IDLE; m_cnt = 0; m_pre = 0;
    end else if (load) begin
      m_cnt = int'(load_val);
      m_pre = 0;
      if (m_st == M_DONE) m_st = M_IDLE;
    end else if (m_st == M_IDLE) begin
      if (start && !stop) begin m_st = M_RUN; m_pre = 0; end
    end else if (m_st == M_PAUSE) begin
      if (start && !stop) m_st = M_RUN;
    end else if (m_st == M_DONE) begin
      if (start && !stop) begin
        m_st = M_RUN; m_pre = 0; m_cnt = dir ? 0 : int'(limit);
      end
    end else begin
      if (stop) m_st = M_PAUSE;
      else if (m_pre != int'(div)) m_pre = (m_pre + 1) % mod_p;
      else begin
        m_pre  = 0;
        m_tick = 1;
        term   = dir ? int'(limit) : 0;
        if (m_cnt != term) m_cnt = dir ? (m_cnt + 1) % mod_c : (m_cnt + mod_c - 1) % mod_c;
        else begin
          m_tc = 1;
          if (reload) m_cnt = dir ? 0 : int'(limit);
          else        m_st  = M_DONE;
        end
      end
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic quiet_inputs();
    rst = 1'b0; start = 1'b0; stop = 1'b0; load = 1'b0;
    dir = 1'b1; reload = 1'b1; load_val = '0; limit = '0; div = '0;
  endtask

  task automatic do_reset();
    quiet_inputs();
    rst = 1'b1;
    cycle();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    quiet_inputs();
    rst = 1'b1; start = 1'b1; load = 1'b1; load_val = 4'd9;
    cycle();
    quiet_inputs();
    n_total++; if (count !== 4'd0) $display("FAIL reset_count: got %0d want 0", count); else n_pass++;
    n_total++; if (tick !== 1'b0) $display("FAIL reset_tick: got %b want 0", tick); else n_pass++;
    n_total++; if (tc !== 1'b0) $display("FAIL reset_tc: got %b want 0", tc); else n_pass++;
    n_total++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", busy); else n_pass++;
    n_total++; if (done !== 1'b0) $display("FAIL reset_done: got %b want 0", done); else n_pass++;
  endtask

  task automatic test_up_reload();
    int ntc;
    ntc = 0;
    do_reset();
    div = 8'd2; dir = 1'b1; limit = 4'd5; reload = 1'b1; start = 1'b1;
    cycle();
    start = 1'b0;
    n_total++; if (busy !== 1'b1 || count !== 4'd0) $display("FAIL up_start: busy=%b cnt=%0d want busy=1 cnt=0", busy, count); else n_pass++;
    for (int i = 0; i < 40; i++) begin
      cycle();
      n_total++;
      if ({count, tick, tc, busy, done} !== {CW'(m_cnt), 1'(m_tick), 1'(m_tc), m_st == M_RUN, m_st == M_DONE})
        $display("FAIL up_reload cyc %0d: dut cnt=%0d tick=%b tc=%b busy=%b done=%b model cnt=%0d tick=%0d tc=%0d st=%0d",
                 i, count, tick, tc, busy, done, m_cnt, m_tick, m_tc, m_st);
      else n_pass++;
      if (tc === 1'b1) begin
        ntc++;
        n_total++; if (count !== 4'd0 || tick !== 1'b1) $display("FAIL up_tc_align: cnt=%0d tick=%b want cnt=0 tick=1", count, tick); else n_pass++;
      end
    end
    n_total++; if (busy !== 1'b1) $display("FAIL up_busy: got %b want 1", busy); else n_pass++;
    n_total++; if (ntc != 2) $display("FAIL up_tc_count: got %0d want 2", ntc); else n_pass++;
  endtask

  task automatic test_down_oneshot();
    int exp_cnt[4] = '{2, 1, 0, 0};
    int exp_end[4] = '{0, 0, 0, 1};
    do_reset();
    div = 8'd0; dir = 1'b0; reload = 1'b0; limit = 4'd3; load_val = 4'd3; load = 1'b1;
    cycle();
    load = 1'b0;
    n_total++; if (count !== 4'd3 || busy !== 1'b0) $display("FAIL down_load: cnt=%0d busy=%b want cnt=3 busy=0", count, busy); else n_pass++;
    start = 1'b1;
    cycle();
    start = 1'b0;
    n_total++; if (busy !== 1'b1 || count !== 4'd3) $display("FAIL down_start: busy=%b cnt=%0d want busy=1 cnt=3", busy, count); else n_pass++;
    for (int i = 0; i < 4; i++) begin
      cycle();
      n_total++;
      if (int'(count) != exp_cnt[i] || int'(tc) != exp_end[i] || int'(done) != exp_end[i] || tick !== 1'b1)
        $display("FAIL down_seq step %0d: cnt=%0d tc=%b done=%b tick=%b want cnt=%0d tc=done=%0d tick=1",
                 i, count, tc, done, tick, exp_cnt[i], exp_end[i]);
      else n_pass++;
    end
    repeat (3) cycle();
    n_total++;
    if (count !== 4'd0 || busy !== 1'b0 || done !== 1'b1 || tc !== 1'b0)
      $display("FAIL down_hold: cnt=%0d busy=%b done=%b tc=%b want 0,0,1,0", count, busy, done, tc);
    else n_pass++;
  endtask

  task automatic test_pause();
    int nt;
    int g;
    logic [CW-1:0] held;
    do_reset();
    div = 8'd4; dir = 1'b1; limit = 4'd15; reload = 1'b1; start = 1'b1;
    cycle();
    start = 1'b0;
    for (int i = 0; i < 20 && tick !== 1'b1; i++) cycle();
    n_total++; if (tick !== 1'b1) $display("FAIL pause_first_step: timeout, tick=%b want 1", tick); else n_pass++;
    cycle();
    cycle();
    stop = 1'b1;
    cycle();
    n_total++; if (busy !== 1'b0) $display("FAIL pause_enter: busy=%b want 0", busy); else n_pass++;
    held = count;
    nt = 0;
    repeat (9) begin cycle(); if (tick === 1'b1) nt++; end
    stop = 1'b0;
    n_total++; if (nt != 0 || count !== held) $display("FAIL pause_hold: ticks=%0d cnt=%0d want ticks=0 cnt=%0d", nt, count, held); else n_pass++;
    start = 1'b1;
    cycle();
    start = 1'b0;
    n_total++; if (busy !== 1'b1) $display("FAIL pause_resume: busy=%b want 1", busy); else n_pass++;
    g = 0;
    for (int i = 1; i <= 10; i++) begin
      cycle();
      if (tick === 1'b1) begin g = i; break; end
    end
    n_total++; if (g != 3) $display("FAIL pause_gap: step %0d cycles after resume, want 3", g); else n_pass++;
    n_total++; if (int'(count) != m_cnt) $display("FAIL pause_count: got %0d want %0d", count, m_cnt); else n_pass++;
  endtask

  task automatic test_load_step();
    do_reset();
    div = 8'd3; dir = 1'b1; limit = 4'd12; reload = 1'b1; start = 1'b1;
    cycle();
    start = 1'b0;
    cycle();
    for (int i = 0; i < 10 && !(m_st == M_RUN && m_pre == int'(div)); i++) cycle();
    load = 1'b1; load_val = 4'd9;
    cycle();
    load = 1'b0;
    n_total++;
    if (count !== 4'd9 || tick !== 1'b0 || busy !== 1'b1)
      $display("FAIL load_step: cnt=%0d tick=%b busy=%b want 9,0,1", count, tick, busy);
    else n_pass++;
    reload = 1'b0; limit = 4'd10; div = 8'd0;
    for (int i = 0; i < 10 && done !== 1'b1; i++) cycle();
    n_total++; if (done !== 1'b1 || count !== 4'd10) $display("FAIL load_reach_done: done=%b cnt=%0d want 1,10", done, count); else n_pass++;
    load = 1'b1; load_val = 4'd2;
    cycle();
    load = 1'b0;
    n_total++;
    if (done !== 1'b0 || busy !== 1'b0 || count !== 4'd2)
      $display("FAIL load_in_done: done=%b busy=%b cnt=%0d want 0,0,2", done, busy, count);
    else n_pass++;
    repeat (3) cycle();
    n_total++; if (tick !== 1'b0 || count !== 4'd2 || busy !== 1'b0) $display("FAIL load_idle_hold: tick=%b cnt=%0d busy=%b want 0,2,0", tick, count, busy); else n_pass++;
  endtask

  task automatic test_start_stop();
    do_reset();
    div = 8'd1; dir = 1'b1; limit = 4'd15; start = 1'b1; stop = 1'b1;
    repeat (3) cycle();
    start = 1'b0; stop = 1'b0;
    n_total++; if (busy !== 1'b0 || count !== 4'd0) $display("FAIL ss_idle: busy=%b cnt=%0d want 0,0", busy, count); else n_pass++;
    start = 1'b1;
    cycle();
    start = 1'b0;
    stop = 1'b1;
    cycle();
    stop = 1'b0;
    n_total++; if (busy !== 1'b0) $display("FAIL ss_to_pause: busy=%b want 0", busy); else n_pass++;
    start = 1'b1; stop = 1'b1;
    repeat (3) cycle();
    start = 1'b0; stop = 1'b0;
    n_total++;
    if (busy !== 1'b0 || done !== 1'b0 || tick !== 1'b0)
      $display("FAIL ss_pause: busy=%b done=%b tick=%b want 0,0,0", busy, done, tick);
    else n_pass++;
    start = 1'b1;
    cycle();
    start = 1'b0;
    n_total++; if (busy !== 1'b1) $display("FAIL ss_resume: busy=%b want 1", busy); else n_pass++;
  endtask

  task automatic test_reset_midrun();
    do_reset();
    div = 8'd1; dir = 1'b1; limit = 4'd15; reload = 1'b1; load = 1'b1; load_val = 4'd7;
    cycle();
    load = 1'b0; start = 1'b1;
    cycle();
    start = 1'b0;
    cycle();
    n_total++; if (count !== 4'd7 || busy !== 1'b1) $display("FAIL rst_mid_setup: cnt=%0d busy=%b want 7,1", count, busy); else n_pass++;
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    n_total++;
    if ({count, tick, tc, busy, done} !== {4'd0, 4'b0000})
      $display("FAIL rst_mid: cnt=%0d tick=%b tc=%b busy=%b done=%b want all 0", count, tick, tc, busy, done);
    else n_pass++;
    cycle();
    n_total++; if (busy !== 1'b0 || count !== 4'd0) $display("FAIL rst_mid_idle: busy=%b cnt=%0d want 0,0", busy, count); else n_pass++;
  endtask

  task automatic test_div_wrap();
    int g;
    do_reset();
    div = 8'd20; dir = 1'b1; limit = 4'd15; reload = 1'b1; start = 1'b1;
    cycle();
    start = 1'b0;
    repeat (15) cycle();
    div = 8'd3;
    g = 0;
    for (int i = 1; i <= 400; i++) begin
      cycle();
      n_total++;
      if ({count, tick, tc, busy, done} !== {CW'(m_cnt), 1'(m_tick), 1'(m_tc), m_st == M_RUN, m_st == M_DONE})
        $display("FAIL div_wrap cyc %0d: dut cnt=%0d tick=%b model cnt=%0d tick=%0d", i, count, tick, m_cnt, m_tick);
      else n_pass++;
      if (tick === 1'b1) begin g = i; break; end
    end
    // Prescaler sits at 15: runs 16..255, wraps to 0, then 1..3, then steps.
    n_total++; if (g != (1 << DW) - 15 + 3 + 1) $display("FAIL div_wrap_gap: got %0d want %0d", g, (1 << DW) - 15 + 3 + 1); else n_pass++;
  endtask

  task automatic test_random();
    do_reset();
    for (int i = 0; i < 1500; i++) begin
      rst   = ($urandom_range(199) == 0);
      load  = ($urandom_range(29) == 0);
      stop  = ($urandom_range(7) == 0);
      start = ($urandom_range(3) == 0);
      load_val = CW'($urandom_range(15));
      if ($urandom_range(39) == 0) begin
        dir    = 1'($urandom_range(1));
        reload = 1'($urandom_range(1));
        limit  = CW'($urandom_range(15));
        div    = DW'($urandom_range(3));
      end
      cycle();
      n_total++;
      if ({count, tick, tc, busy, done} !== {CW'(m_cnt), 1'(m_tick), 1'(m_tc), m_st == M_RUN, m_st == M_DONE})
        $display("FAIL random cyc %0d: dut cnt=%0d tick=%b tc=%b busy=%b done=%b model cnt=%0d tick=%0d tc=%0d st=%0d",
                 i, count, tick, tc, busy, done, m_cnt, m_tick, m_tc, m_st);
      else n_pass++;
    end
    quiet_inputs();
  endtask

  initial begin
    quiet_inputs();
    test_reset();
    test_up_reload();
    test_down_oneshot();
    test_pause();
    test_load_step();
    test_start_stop();
    test_reset_midrun();
    test_div_wrap();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, passed %0d of %0d", n_pass, n_total);
    $fatal(1, "watchdog");
  end

endmodule
